// File: rtl/rx_parser_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_parser_arbiter_if
// Purpose  : Bundle of MAC receive streams and parser-side strobes shared
//            between the RX parser arbiter and its surroundings.
// Revision : 1.0  initial release
// ============================================================================
interface rx_parser_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
);
    // MAC receive side, one lane per port
    logic [64*NUM_PORTS-1:0] in_data;
    logic [NUM_PORTS-1:0]    in_valid;
    logic [NUM_PORTS-1:0]    in_sop;
    logic [NUM_PORTS-1:0]    in_eop;
    logic [NUM_PORTS-1:0]    in_ready;

    // Parser / packetizer side
    logic [63:0]             pz_data;
    logic                    pz_en;
    logic                    pz_start_packet;
    logic                    pz_end_packet;
    logic [PORT_W-1:0]       pz_port;

    // Status
    logic                    truncated;
    logic [31:0]             pkt_count;
    logic [15:0]             drop_count;
    logic [15:0]             trunc_count;

    // Environment view: drives the streams, observes everything else
    modport master (
        output in_data, in_valid, in_sop, in_eop,
        input  in_ready,
        input  pz_data, pz_en, pz_start_packet, pz_end_packet, pz_port,
        input  truncated, pkt_count, drop_count, trunc_count
    );

    // Arbiter view
    modport slave (
        input  in_data, in_valid, in_sop, in_eop,
        output in_ready,
        output pz_data, pz_en, pz_start_packet, pz_end_packet, pz_port,
        output truncated, pkt_count, drop_count, trunc_count
    );
endinterface
`default_nettype wire

// File: rtl/rx_parser_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rx_parser_arbiter
// Purpose  : Packet-granular round-robin arbiter sharing one RX header
//            parser among NUM_PORTS MAC streams. Holds a grant for a whole
//            packet, forwards beats registered, forces an idle gap after each
//            packet and truncates packets longer than MAX_BEATS.
// Revision : 1.0  initial release
// ============================================================================
module rx_parser_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_W     = 2,
    parameter int GAP_CYCLES = 2,
    parameter int MAX_BEATS  = 190
) (
    input  logic               clk,
    input  logic               reset,
    rx_parser_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int                  c_bcnt_w    = $clog2(MAX_BEATS + 1);
    localparam logic [c_bcnt_w-1:0] c_max_beats = c_bcnt_w'(MAX_BEATS);
    localparam logic [3:0]          c_gap_last  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PORT_W-1:0]   c_rr_init   = PORT_W'(NUM_PORTS - 1);
    // With no gap configured the arbiter can re-arbitrate right after a packet
    localparam state_t              c_after_end = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t                r_state, w_state_nxt;
    logic [PORT_W-1:0]     r_rr_last;      // last granted port, drives rotation
    logic [PORT_W-1:0]     r_gnt;          // current owner, also reported as pz_port
    logic [c_bcnt_w-1:0]   r_beat_cnt, w_bcnt_nxt, w_bcnt_inc;
    logic [3:0]            r_gap_cnt, w_gap_nxt;
    logic [63:0]           r_data;
    logic                  r_en, r_start, r_end, r_trunc;
    logic [31:0]           r_pkt_cnt;
    logic [15:0]           r_drop_cnt, r_trunc_cnt;

    logic [NUM_PORTS-1:0]  w_cand, w_orph_vec, w_orph_oh, w_ready;
    logic [PORT_W-1:0]     w_sel, w_src;
    logic                  w_found;
    int                    w_idx;
    logic [63:0]           w_src_data;
    logic                  w_fwd, w_start, w_end, w_trunc, w_tinc, w_drop, w_grant;

    assign w_bcnt_inc = r_beat_cnt + c_bcnt_w'(1);
    assign w_src_data = bus.in_data[64*w_src +: 64];

    // Orphan beats: lowest-index valid non-sop port, isolated as a one-hot
    assign w_orph_vec = bus.in_valid & ~bus.in_sop;
    assign w_orph_oh  = w_orph_vec & (~w_orph_vec + NUM_PORTS'(1));

    // Round-robin search for the next sop candidate after the last grant
    always_comb begin
        w_cand  = bus.in_valid & bus.in_sop;
        w_found = 1'b0;
        w_sel   = r_rr_last;
        w_idx   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_idx = int'(r_rr_last) + k;
            if (w_idx >= NUM_PORTS) begin
                w_idx = w_idx - NUM_PORTS;
            end
            if (!w_found && w_cand[PORT_W'(w_idx)]) begin
                w_found = 1'b1;
                w_sel   = PORT_W'(w_idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, ready steering and per-beat event strobes
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_src       = r_gnt;
        w_fwd       = 1'b0;
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_trunc     = 1'b0;
        w_tinc      = 1'b0;
        w_drop      = 1'b0;
        w_grant     = 1'b0;
        w_bcnt_nxt  = r_beat_cnt;
        w_gap_nxt   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_src          = w_sel;
                    w_ready[w_sel] = 1'b1;
                    w_fwd          = 1'b1;
                    w_start        = 1'b1;
                    w_grant        = 1'b1;
                    w_bcnt_nxt     = c_bcnt_w'(1);
                    if (bus.in_eop[w_sel]) begin
                        w_end       = 1'b1;
                        w_state_nxt = c_after_end;
                    end else begin
                        w_state_nxt = ST_XFER;
                    end
                end else if (|w_orph_oh) begin
                    w_ready = w_orph_oh;
                    w_drop  = 1'b1;
                end
            end
            ST_XFER: begin
                w_ready[r_gnt] = 1'b1;
                if (bus.in_valid[r_gnt]) begin
                    w_fwd      = 1'b1;
                    w_bcnt_nxt = w_bcnt_inc;
                    if (bus.in_sop[r_gnt]) begin
                        // New sop without a closing eop: close the open packet here
                        w_end       = 1'b1;
                        w_tinc      = 1'b1;
                        w_state_nxt = c_after_end;
                    end else if (bus.in_eop[r_gnt]) begin
                        w_end       = 1'b1;
                        w_state_nxt = c_after_end;
                    end else if (w_bcnt_inc == c_max_beats) begin
                        w_end       = 1'b1;
                        w_trunc     = 1'b1;
                        w_tinc      = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_ready[r_gnt] = 1'b1;
                if (bus.in_valid[r_gnt] && bus.in_eop[r_gnt]) begin
                    w_state_nxt = c_after_end;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered parser strobes, grant bookkeeping and statistics counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_last   <= c_rr_init;
            r_gnt       <= '0;
            r_beat_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_data      <= '0;
            r_en        <= 1'b0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_trunc     <= 1'b0;
            r_pkt_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_trunc_cnt <= '0;
        end else begin
            r_en       <= w_fwd;
            r_start    <= w_start;
            r_end      <= w_end;
            r_trunc    <= w_trunc;
            r_beat_cnt <= w_bcnt_nxt;
            r_gap_cnt  <= w_gap_nxt;
            if (w_fwd) begin
                r_data <= w_src_data;
            end
            if (w_grant) begin
                r_rr_last <= w_sel;
                r_gnt     <= w_sel;
            end
            if (w_end) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_tinc) begin
                r_trunc_cnt <= r_trunc_cnt + 16'd1;
            end
        end
    end

    assign bus.in_ready        = w_ready;
    assign bus.pz_data         = r_data;
    assign bus.pz_en           = r_en;
    assign bus.pz_start_packet = r_start;
    assign bus.pz_end_packet   = r_end;
    assign bus.pz_port         = r_gnt;
    assign bus.truncated       = r_trunc;
    assign bus.pkt_count       = r_pkt_cnt;
    assign bus.drop_count      = r_drop_cnt;
    assign bus.trunc_count     = r_trunc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rx_parser_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_parser_arbiter
// Purpose  : Self-checking bench for rx_parser_arbiter: scripted per-port beat
//            queues, a packet-level reference model and literal scenario checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_rx_parser_arbiter;
    localparam int NP   = 4;
    localparam int PW   = 2;
    localparam int GAP  = 2;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rx_parser_arbiter_if #(.NUM_PORTS(NP), .PORT_W(PW)) bus ();

    rx_parser_arbiter #(
        .NUM_PORTS (NP),
        .PORT_W    (PW),
        .GAP_CYCLES(GAP),
        .MAX_BEATS (MAXB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        bit          idle;
        logic [63:0] data;
        bit          sop;
        bit          eop;
    } beat_t;

    beat_t q [NP][$];

    int checks, errors, cyc;

    // current stimulus
    logic [NP-1:0] cur_v, cur_s, cur_e;
    logic [63:0]   cur_d [NP];

    // reference model
    bit          m_busy, m_drain;
    int          m_gap_left, m_last, m_owner, m_sent;
    logic [63:0] e_data;
    bit          e_en, e_start, e_end, e_trunc;
    int          e_port;
    logic [31:0] e_pkt;
    logic [15:0] e_drop, e_tcnt;

    // scenario observations
    int en_seen, tr_seen, both_seen, end_seen, idle_run, first_en, last_en, acc_sop_cyc;
    bit have_end;
    int starts[$];
    int gaps[$];
    int t2_exp[6] = '{0, 1, 2, 0, 1, 2};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_drain = 0; m_gap_left = 0; m_last = NP - 1; m_owner = 0; m_sent = 0;
        e_data = '0; e_en = 0; e_start = 0; e_end = 0; e_trunc = 0; e_port = 0;
        e_pkt = '0; e_drop = '0; e_tcnt = '0;
    endtask

    function automatic bit model_idle();
        return !m_busy && !m_drain && (m_gap_left == 0);
    endfunction

    // Which port the arbiter must accept from, given what is being offered
    function automatic logic [NP-1:0] model_ready(input logic [NP-1:0] v, input logic [NP-1:0] s);
        logic [NP-1:0] r;
        r = '0;
        if (m_gap_left > 0) return r;
        if (m_busy || m_drain) begin
            r[m_owner] = 1'b1;
            return r;
        end
        for (int k = 1; k <= NP; k++) begin
            int p;
            p = (m_last + k) % NP;
            if (v[p] && s[p]) begin
                r[p] = 1'b1;
                return r;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (v[p] && !s[p]) begin
                r[p] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_step(input logic [NP-1:0] acc);
        e_en = 0; e_start = 0; e_end = 0; e_trunc = 0;
        if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (m_drain) begin
            if (acc[m_owner] && cur_e[m_owner]) begin
                m_drain    = 0;
                m_gap_left = GAP;
            end
        end else if (m_busy) begin
            if (acc[m_owner]) begin
                e_en   = 1;
                e_data = cur_d[m_owner];
                m_sent++;
                if (cur_s[m_owner]) begin
                    e_end = 1; e_pkt++; e_tcnt++; m_busy = 0; m_gap_left = GAP;
                end else if (cur_e[m_owner]) begin
                    e_end = 1; e_pkt++; m_busy = 0; m_gap_left = GAP;
                end else if (m_sent == MAXB) begin
                    e_end = 1; e_trunc = 1; e_tcnt++; e_pkt++; m_busy = 0; m_drain = 1;
                end
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) begin
                    if (cur_s[p]) begin
                        m_last = p; m_owner = p; e_port = p;
                        e_en = 1; e_start = 1; e_data = cur_d[p]; m_sent = 1;
                        if (cur_e[p]) begin
                            e_end = 1; e_pkt++; m_gap_left = GAP;
                        end else begin
                            m_busy = 1;
                        end
                    end else begin
                        e_drop++;
                    end
                end
            end
        end
    endtask

    task automatic push_beat(input int p, input bit sop, input bit eop);
        beat_t b;
        b.idle = 0; b.data = {$urandom, $urandom}; b.sop = sop; b.eop = eop;
        q[p].push_back(b);
    endtask

    task automatic push_idle(input int p);
        beat_t b;
        b.idle = 1; b.data = {$urandom, $urandom}; b.sop = 0; b.eop = 0;
        q[p].push_back(b);
    endtask

    task automatic push_pkt(input int p, input int len);
        for (int b = 0; b < len; b++) push_beat(p, b == 0, b == len - 1);
    endtask

    function automatic bit q_nonempty();
        for (int p = 0; p < NP; p++) if (q[p].size() > 0) return 1;
        return 0;
    endfunction

    task automatic drive();
        logic [64*NP-1:0] d;
        d = '0;
        for (int p = 0; p < NP; p++) begin
            if (q[p].size() > 0) begin
                cur_v[p] = !q[p][0].idle;
                cur_s[p] = q[p][0].sop;
                cur_e[p] = q[p][0].eop;
                cur_d[p] = q[p][0].data;
            end else begin
                cur_v[p] = 0; cur_s[p] = 0; cur_e[p] = 0; cur_d[p] = '0;
            end
            d[64*p +: 64] = cur_d[p];
        end
        bus.in_valid = cur_v;
        bus.in_sop   = cur_s;
        bus.in_eop   = cur_e;
        bus.in_data  = d;
    endtask

    task automatic advance(input logic [NP-1:0] acc);
        for (int p = 0; p < NP; p++) begin
            if (q[p].size() > 0 && (q[p][0].idle || acc[p])) void'(q[p].pop_front());
        end
    endtask

    task automatic clear_obs();
        en_seen = 0; tr_seen = 0; both_seen = 0; end_seen = 0; idle_run = 0;
        first_en = -1; last_en = -1; acc_sop_cyc = -1; have_end = 0;
        starts.delete(); gaps.delete();
    endtask

    task automatic observe();
        if (bus.pz_en) begin
            en_seen++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
        end
        if (bus.truncated) tr_seen++;
        if (bus.pz_start_packet) begin
            starts.push_back(int'(bus.pz_port));
            if (have_end) gaps.push_back(idle_run);
        end
        if (bus.pz_start_packet && bus.pz_end_packet) both_seen++;
        if (bus.pz_end_packet) begin
            end_seen++; have_end = 1; idle_run = 0;
        end else if (!bus.pz_en) begin
            idle_run++;
        end
    endtask

    // One clock of the compare process: outputs, stimulus, ready, model update
    task automatic step();
        logic [NP-1:0] mr, acc;
        @(negedge clk);
        cyc++;
        chk("pz_en", bus.pz_en, e_en);
        chk("pz_data", bus.pz_data, e_data);
        chk("pz_start_packet", bus.pz_start_packet, e_start);
        chk("pz_end_packet", bus.pz_end_packet, e_end);
        chk("pz_port", bus.pz_port, e_port);
        chk("truncated", bus.truncated, e_trunc);
        chk("pkt_count", bus.pkt_count, e_pkt);
        chk("drop_count", bus.drop_count, e_drop);
        chk("trunc_count", bus.trunc_count, e_tcnt);
        observe();
        drive();
        #1;
        mr = model_ready(cur_v, cur_s);
        chk("in_ready", bus.in_ready, mr);
        if (acc_sop_cyc < 0 && |(bus.in_ready & cur_v & cur_s)) acc_sop_cyc = cyc;
        acc = cur_v & mr;
        model_step(acc);
        advance(acc);
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((q_nonempty() || !model_idle()) && n < budget) begin
            step();
            n++;
        end
        if (q_nonempty() || !model_idle()) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
        end
        step();
        step();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pz_en"}, bus.pz_en, 0);
        chk({tag, "_pz_data"}, bus.pz_data, 0);
        chk({tag, "_pz_start"}, bus.pz_start_packet, 0);
        chk({tag, "_pz_end"}, bus.pz_end_packet, 0);
        chk({tag, "_pz_port"}, bus.pz_port, 0);
        chk({tag, "_truncated"}, bus.truncated, 0);
        chk({tag, "_pkt_count"}, bus.pkt_count, 0);
        chk({tag, "_drop_count"}, bus.drop_count, 0);
        chk({tag, "_trunc_count"}, bus.trunc_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0;
        reset = 1'b1;
        model_reset();
        clear_obs();
        drive();
        @(negedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        chk("reset_in_ready", bus.in_ready, 0);
        reset = 1'b0;

        // Three ports with back-to-back 2-beat packets: strict rotation 0,1,2
        clear_obs();
        for (int r = 0; r < 2; r++) for (int p = 0; p < 3; p++) push_pkt(p, 2);
        run_until_idle("t_rr", 300);
        chk("t_rr_starts", starts.size(), 6);
        for (int i = 0; i < starts.size() && i < 6; i++) chk("t_rr_order", starts[i], t2_exp[i]);
        chk("t_rr_gaps", gaps.size(), 5);
        foreach (gaps[i]) chk("t_rr_gap_len", gaps[i], 2);
        chk("t_rr_pkt_count", bus.pkt_count, 6);

        // Single 3-beat packet on port 0
        clear_obs();
        push_pkt(0, 3);
        run_until_idle("t_3beat", 100);
        chk("t_3beat_en", en_seen, 3);
        chk("t_3beat_span", last_en - first_en + 1, 3);
        chk("t_3beat_latency", first_en - acc_sop_cyc, 1);
        chk("t_3beat_ends", end_seen, 1);
        chk("t_3beat_pkt_count", bus.pkt_count, 7);

        // One-beat packet on port 3
        clear_obs();
        push_pkt(3, 1);
        run_until_idle("t_1beat", 100);
        chk("t_1beat_en", en_seen, 1);
        chk("t_1beat_start_end", both_seen, 1);
        chk("t_1beat_port", (starts.size() > 0) ? starts[0] : -1, 3);
        chk("t_1beat_pkt_count", bus.pkt_count, 8);

        // 7-beat packet on port 1 is cut after MAXB beats
        clear_obs();
        push_pkt(1, 7);
        run_until_idle("t_trunc", 100);
        chk("t_trunc_en", en_seen, 4);
        chk("t_trunc_pulses", tr_seen, 1);
        chk("t_trunc_ends", end_seen, 1);
        chk("t_trunc_count", bus.trunc_count, 1);
        chk("t_trunc_pkt_count", bus.pkt_count, 9);

        // Exactly MAXB beats with eop: not a truncation
        clear_obs();
        push_pkt(1, 4);
        run_until_idle("t_exact", 100);
        chk("t_exact_en", en_seen, 4);
        chk("t_exact_pulses", tr_seen, 0);
        chk("t_exact_trunc_count", bus.trunc_count, 1);
        chk("t_exact_pkt_count", bus.pkt_count, 10);

        // Orphan beats on port 2 in IDLE
        clear_obs();
        for (int i = 0; i < 3; i++) push_beat(2, 0, 0);
        run_until_idle("t_orphan", 50);
        chk("t_orphan_drop_count", bus.drop_count, 3);
        chk("t_orphan_en", en_seen, 0);

        // Reset while beat 2 of a 5-beat packet is in flight
        push_pkt(0, 5);
        n = 0;
        while (!(m_busy && m_sent == 2) && n < 30) begin
            step();
            n++;
        end
        chk("t_rst_reached_beat2", m_sent, 2);
        @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < NP; p++) q[p].delete();
        drive();
        #1;
        chk_zero_outputs("t_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_obs();
        push_pkt(1, 2);
        push_pkt(0, 2);
        run_until_idle("t_rst_after", 100);
        chk("t_rst_starts", starts.size(), 2);
        chk("t_rst_first_port", (starts.size() > 0) ? starts[0] : -1, 0);
        chk("t_rst_second_port", (starts.size() > 1) ? starts[1] : -1, 1);
        chk("t_rst_latency", first_en - acc_sop_cyc, 1);
        chk("t_rst_pkt_count", bus.pkt_count, 2);

        // Randomised traffic: bubbles, orphans, long and unterminated packets
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 6; k++) begin
                int len;
                bit miss;
                if ($urandom_range(0, 3) == 0) begin
                    for (int o = 0; o < int'($urandom_range(1, 2)); o++) push_beat(p, 0, 0);
                end
                len  = $urandom_range(1, 7);
                miss = (k < 5) && ($urandom_range(0, 7) == 0);
                for (int b = 0; b < len; b++) begin
                    if ($urandom_range(0, 3) == 0) push_idle(p);
                    push_beat(p, b == 0, (b == len - 1) && !miss);
                end
            end
        end
        run_until_idle("t_random", 5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
